// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared widths and types for the 1x16 deserializer
package demux_pkg;

  localparam int N    = 16;
  localparam int SELW = $clog2(N);

  typedef logic [N-1:0]    word_t;
  typedef logic [SELW-1:0] sel_t;

  localparam sel_t SEL_LAST = sel_t'(N - 1);
  localparam sel_t SEL_ONE  = sel_t'(1);

endpackage

// File: rtl/demux_1x16.sv
// rtl/demux_1x16.sv - one-hot 1-to-16 write-enable decoder, inverse of the 16x1 mux
module demux_1x16
  import demux_pkg::*;
(
  input  logic [SELW-1:0] sel,
  input  logic            en,
  output logic [N-1:0]    we
);

  always_comb begin
    we = '0;
    if (en) we[sel] = 1'b1;
  end

endmodule

// File: rtl/demux_1x16_deser.sv
// rtl/demux_1x16_deser.sv - serial-to-16-bit deserializer with sof realignment and valid/ready output
module demux_1x16_deser
  import demux_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            din_valid,
  input  logic            din,
  input  logic            sof,
  output logic            din_ready,
  output logic [SELW-1:0] sel,
  output logic [N-1:0]    y,
  output logic            y_valid,
  input  logic            y_ready,
  output logic            err_abort,
  output logic [7:0]      word_cnt
);

  word_t asm_q;
  word_t we;
  word_t asm_wr;
  logic  accept;
  logic  take_sof;
  logic  take_bit;
  logic  complete;

  // Only the final bit can stall: it would overwrite a word still held downstream.
  assign din_ready = !((sel == SEL_LAST) && y_valid && !y_ready);
  assign accept    = din_valid && din_ready && !clear;
  assign take_sof  = accept && sof;
  assign take_bit  = accept && !sof;
  assign complete  = take_bit && (sel == SEL_LAST);

  demux_1x16 u_demux (
    .sel (sel),
    .en  (take_bit),
    .we  (we)
  );

  assign asm_wr = (asm_q & ~we) | (we & {N{din}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= '0;
      asm_q     <= '0;
      y         <= '0;
      y_valid   <= 1'b0;
      err_abort <= 1'b0;
      word_cnt  <= '0;
    end else if (clear) begin
      sel       <= '0;
      asm_q     <= '0;
      y_valid   <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      err_abort <= 1'b0;
      if (y_valid && y_ready) y_valid <= 1'b0;
      if (take_sof) begin
        // sof always restarts at bit 0; a nonzero index means a frame was cut short.
        asm_q     <= {{(N-1){1'b0}}, din};
        sel       <= SEL_ONE;
        err_abort <= (sel != '0);
      end else if (complete) begin
        y        <= {din, asm_q[N-2:0]};
        y_valid  <= 1'b1;
        sel      <= '0;
        asm_q    <= '0;
        word_cnt <= word_cnt + 8'd1;
      end else if (take_bit) begin
        asm_q <= asm_wr;
        sel   <= sel + SEL_ONE;
      end
    end
  end

endmodule

// File: tb/tb_demux_1x16_deser.sv
// tb/tb_demux_1x16_deser.sv - directed self-checking bench for demux_1x16_deser
module tb_demux_1x16_deser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        din_valid;
  logic        din;
  logic        sof;
  logic        din_ready;
  logic [3:0]  sel;
  logic [15:0] y;
  logic        y_valid;
  logic        y_ready;
  logic        err_abort;
  logic [7:0]  word_cnt;

  int vectors     = 0;
  int miscompares = 0;
  logic err_seen  = 1'b0;
  logic hs_en     = 1'b0;
  int   hs_cnt    = 0;

  always #5 clk = ~clk;

  demux_1x16_deser dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .din_valid (din_valid),
    .din       (din),
    .sof       (sof),
    .din_ready (din_ready),
    .sel       (sel),
    .y         (y),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .err_abort (err_abort),
    .word_cnt  (word_cnt)
  );

  always @(posedge clk) begin
    if (err_abort) err_seen <= 1'b1;
    if (hs_en && y_valid && y_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic b, input logic s);
    din_valid = v;
    din       = b;
    sof       = s;
    step();
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 16; i++) put(1'b1, w[i], i == 0);
    din_valid = 1'b0;
    sof       = 1'b0;
  endtask

  initial begin
    logic [15:0] w;

    rst_n = 1'b0; clear = 1'b0; din_valid = 1'b0; din = 1'b0; sof = 1'b0; y_ready = 1'b1;
    step(); step();
    check("rst_sel", sel, 0);
    check("rst_y", y, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_err", err_abort, 0);
    check("rst_cnt", word_cnt, 0);
    rst_n = 1'b1;
    step();

    // 1: basic word
    err_seen = 1'b0;
    send_word(16'b1111_1010_0001_0110);
    check("basic_valid", y_valid, 1);
    check("basic_y", y, 16'hFA16);
    check("basic_cnt", word_cnt, 1);
    check("basic_sel", sel, 0);
    step();
    check("basic_pulse", y_valid, 0);
    check("basic_noerr", err_seen, 0);

    // 2: backpressure
    y_ready = 1'b0;
    send_word(16'hFA16);
    check("bp_valid1", y_valid, 1);
    check("bp_cnt1", word_cnt, 2);
    w = 16'h0001;
    for (int i = 0; i < 15; i++) put(1'b1, w[i], i == 0);
    check("bp_sel15", sel, 15);
    check("bp_hold_valid", y_valid, 1);
    din_valid = 1'b1; din = w[15]; sof = 1'b0;
    #1;
    check("bp_stall", din_ready, 0);
    step();
    check("bp_sel_held", sel, 15);
    check("bp_y_held", y, 16'hFA16);
    y_ready = 1'b1;
    #1;
    check("bp_release", din_ready, 1);
    step();
    check("bp_y2", y, 16'h0001);
    check("bp_valid2", y_valid, 1);
    check("bp_cnt2", word_cnt, 3);
    check("bp_sel0", sel, 0);
    din_valid = 1'b0;
    step();
    check("bp_drain", y_valid, 0);

    // 3: abort by sof mid-frame
    put(1'b1, 1'b1, 1'b1);
    put(1'b1, 1'b0, 1'b0);
    put(1'b1, 1'b1, 1'b0);
    put(1'b1, 1'b1, 1'b0);
    put(1'b1, 1'b0, 1'b0);
    check("ab_sel5", sel, 5);
    check("ab_noerr", err_abort, 0);
    w = 16'h8001;
    put(1'b1, w[0], 1'b1);
    check("ab_err", err_abort, 1);
    check("ab_sel1", sel, 1);
    put(1'b1, w[1], 1'b0);
    check("ab_err_clr", err_abort, 0);
    for (int i = 2; i < 16; i++) put(1'b1, w[i], 1'b0);
    din_valid = 1'b0;
    check("ab_y", y, 16'h8001);
    check("ab_valid", y_valid, 1);
    check("ab_cnt", word_cnt, 4);
    step();

    // 4: gapped input
    w = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      put(1'b1, w[i], i == 0);
      put(1'b0, ~w[i], 1'b0);
      check("gap_sel", sel, (i + 1) % 16);
    end
    check("gap_y", y, 16'hA5C3);
    check("gap_cnt", word_cnt, 5);

    // 5a: async reset mid-word
    w = 16'h3C3C;
    for (int i = 0; i < 7; i++) put(1'b1, w[i], i == 0);
    din_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("ar_sel", sel, 0);
    check("ar_y", y, 0);
    check("ar_valid", y_valid, 0);
    check("ar_cnt", word_cnt, 0);
    step();
    rst_n = 1'b1;
    step();

    // 5b: clear mid-word
    y_ready = 1'b0;
    send_word(16'h1234);
    check("cl_y0", y, 16'h1234);
    check("cl_valid0", y_valid, 1);
    w = 16'h5A5A;
    for (int i = 0; i < 9; i++) put(1'b1, w[i], i == 0);
    check("cl_sel9", sel, 9);
    clear = 1'b1; din_valid = 1'b1; din = 1'b1;
    step();
    clear = 1'b0; din_valid = 1'b0;
    check("cl_sel", sel, 0);
    check("cl_valid", y_valid, 0);
    check("cl_y_kept", y, 16'h1234);
    check("cl_cnt_kept", word_cnt, 1);
    y_ready = 1'b1;
    send_word(16'hBEEF);
    check("cl_y_new", y, 16'hBEEF);
    check("cl_valid_new", y_valid, 1);
    check("cl_cnt_new", word_cnt, 2);
    step();

    // 6: word counter wrap over 256 back-to-back words
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    hs_cnt = 0;
    hs_en  = 1'b1;
    for (int k = 0; k < 256; k++) begin
      w = (16'(k) * 16'h0101) ^ 16'h5A3C;
      send_word(w);
      check("wrap_y", y, w);
      check("wrap_cnt", word_cnt, (k + 1) % 256);
    end
    step();
    hs_en = 1'b0;
    check("wrap_cnt_zero", word_cnt, 0);
    check("wrap_handshakes", hs_cnt, 256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux_1x16_deser.md
Name: demux_1x16_deser

Overview:
Receive-end counterpart of the 16:1 select-walk serializer. It accepts one serial bit per handshake and steers each bit through a 1-to-16 demux into bit position `sel` of an assembly register (`sel` is an internal 4-bit index). After 16 bits it presents the completed word on a valid/ready output. It sits downstream of any 16x1 mux stream whose select runs 0..15, LSB first, and reconstructs the original 16-bit data word.

Parameters:
N, 16, word width / number of demux outputs
SELW, 4, select/index width, fixed at clog2(N)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of partial word and output
din_valid  input  1  serial bit present
din  input  1  serial data bit
sof  input  1  start-of-frame; qualifies din as bit 0
din_ready  output  1  bit accepted this cycle when din_valid=1
sel  output  SELW  current demux index (next bit position)
y  output  N  assembled word
y_valid  output  1  y holds a complete word
y_ready  input  1  downstream accepts y
err_abort  output  1  one-cycle pulse: partial word discarded by sof
word_cnt  output  8  completed words, wraps 255->0

Behaviour:
- Reset (rst_n=0, async): sel=0, asm=0, y=0, y_valid=0, err_abort=0, word_cnt=0.
- accept = din_valid && din_ready.
- din_ready = !(sel==N-1 && y_valid && !y_ready). This is combinational from y_ready; there is no other stall.
- On accept without sof: asm[sel] <= din; sel <= sel+1.
- On accept with sof: asm <= {0..., din}; sel <= 1.
- sof with sel!=0: err_abort=1 for the next cycle only.
- sof with sel==0: normal start, no error.
- Completion: accept with sel==N-1 (without sof) does all of the following:
  - y <= {din, asm[N-2:0]}
  - y_valid <= 1
  - sel <= 0
  - asm <= 0
  - word_cnt += 1
- Latency: y_valid rises the clock edge after the 16th bit is accepted.
- Output handshake: y_valid && y_ready clears y_valid next cycle unless a completion occurs in the same cycle. In that case y loads the new word and y_valid stays 1, so words flow back-to-back with no gap.
- y is stable while y_valid && !y_ready.
- Bits 0..14 are accepted freely even while y_valid is held. Only bit 15 stalls.
- sof on bit 15 of an aborted frame is treated as sof: restart at index 0 and flag abort. No completion occurs.
- clear (sync, priority over all except rst_n): sel=0, asm=0, y_valid=0, err_abort=0; y and word_cnt retained. din is not accepted that cycle; din_ready is don't-care.
- din_valid=0 holds all state; err_abort self-clears.
- sel wrap-around 15->0 happens only via completion; sel is never observed at 16.

Decomposition:
- Package demux_pkg: N, SELW, typedef logic [N-1:0] word_t, typedef logic [SELW-1:0] sel_t.
- Sub-module demux_1x16: combinational one-hot decoder (sel, en) -> N-bit write enable. It is the direct inverse of the 16x1 mux.
- Top holds the index counter, assembly register, output register/handshake and flags.

Test Plan:
1. Basic word: stream the bits of 16'b1111_1010_0001_0110 LSB first, one per cycle, din_valid=1, sof on the first bit, y_ready=1 -> y=16'hFA16, y_valid pulses 1 cycle after the 16th bit, word_cnt=1, err_abort never set.
2. Backpressure: two back-to-back words 16'hFA16 then 16'h0001 with y_ready=0 -> din_ready drops only when sel=15, y holds 16'hFA16. After y_ready=1 for one cycle, the 16th bit is accepted and y becomes 16'h0001 with y_valid continuously 1.
3. Abort: send 5 bits, then sof with din=1 -> err_abort=1 for one cycle. The new frame of 16'h8001 completes correctly with y=16'h8001.
4. Gapped input: 16'hA5C3 with din_valid toggling 1/0 -> same y=16'hA5C3, sel advances only on accepted bits.
5. Reset/clear mid-word: assert rst_n=0 after 7 bits -> all outputs 0 immediately. Separately, pulse clear after 9 bits -> sel=0, y_valid=0, prior y retained, and the next 16 bits yield the correct word.
6. Counter wrap: 256 consecutive words -> word_cnt returns to 0, no lost y_valid.
